reg_load_ctrl: RTL

//  Write-side initiator for the Register_32 bank: it drives each register's shared din and its own load strobe.

---
 rtl/reg_load_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/reg_load_ctrl.sv
// Write-side initiator for a Register_32 bank: buffers {dest,data} requests in a 2-entry FIFO, issues one-hot single-cycle load strobes.
// Latency: accept at edge N -> load_o in cycle N+1; backpressure via registered req_ready (=!full). Optional readback check under `LOAD_VERIFY_EN`.
// Throughput is 1 write/cycle by default, 1 write/2 cycles with LOAD_VERIFY_EN.
module reg_load_ctrl #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_W     = 3,
  parameter int R0_PROTECT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_dest,
  input  logic [31:0]         req_data,
  output logic [31:0]         din_o,
  output logic [NUM_REGS-1:0] load_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   rd_sel_o,
  input  logic [31:0]         rd_data_i
);

  localparam logic [ADDR_W:0]     NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] LOAD_ONE   = NUM_REGS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0][ADDR_W-1:0]  fifo_dest_q, fifo_dest_d;
  logic [1:0][31:0]        fifo_data_q, fifo_data_d;
  logic                    ready_q, ready_d;
  logic [NUM_REGS-1:0]     load_q, load_d;
  logic [31:0]             din_q, din_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic                    push, pop, can_pop;
  logic [ADDR_W-1:0]       hd_dest;
  logic [31:0]             hd_data;
  logic                    hd_in_range, hd_r0, hd_real;

  assign hd_dest     = fifo_dest_q[rd_ptr_q];
  assign hd_data     = fifo_data_q[rd_ptr_q];
  assign hd_in_range = ({1'b0, hd_dest} < NUM_REGS_W);
  assign hd_r0       = (R0_PROTECT != 0) && (hd_dest == '0);
  assign hd_real     = hd_in_range && !hd_r0;

  // ready_q reflects the count after the previous edge, so a full FIFO never
  // accepts even when it is popped on the same edge.
  assign push = req_valid && ready_q;
  assign pop  = can_pop && (cnt_q != 2'd0);

`ifdef LOAD_VERIFY_EN
  logic              wr_real_q, wr_real_d;
  logic [ADDR_W-1:0] rd_sel_q, rd_sel_d;

  // A real write must be read back before the next pop; discarded ones need not.
  assign can_pop = (state_q == S_IDLE) || (state_q == S_VERIFY) ||
                   ((state_q == S_LOAD) && !wr_real_q);
`else
  logic unused_rd;

  assign unused_rd = ^rd_data_i;
  assign can_pop   = 1'b1;
`endif

  always_comb begin
    state_d = S_IDLE;
    load_d  = '0;
    err_d   = 1'b0;
    din_d   = din_q;
`ifdef LOAD_VERIFY_EN
    wr_real_d = wr_real_q;
    rd_sel_d  = rd_sel_q;
    if (state_q == S_LOAD && wr_real_q) begin
      state_d = S_VERIFY;
    end
    if (state_q == S_VERIFY) begin
      err_d = (rd_data_i != din_q);
    end
`endif
    if (pop) begin
      state_d = S_LOAD;
      din_d   = hd_data;
      err_d   = err_d | !hd_in_range;
      if (hd_real) begin
        load_d = LOAD_ONE << hd_dest;
      end
`ifdef LOAD_VERIFY_EN
      wr_real_d = hd_real;
      if (hd_real) begin
        rd_sel_d = hd_dest;
      end
`endif
    end
  end

  always_comb begin
    fifo_dest_d = fifo_dest_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_dest_d[wr_ptr_q] = req_dest;
      fifo_data_d[wr_ptr_q] = req_data;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d   = cnt_q + 2'(push) - 2'(pop);
    ready_d = (cnt_d != 2'd2);
    busy_d  = (cnt_d != 2'd0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_dest_q <= '0;
      fifo_data_q <= '0;
      ready_q     <= 1'b0;
      load_q      <= '0;
      din_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_dest_q <= fifo_dest_d;
      fifo_data_q <= fifo_data_d;
      ready_q     <= ready_d;
      load_q      <= load_d;
      din_q       <= din_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef LOAD_VERIFY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_real_q <= 1'b0;
      rd_sel_q  <= '0;
    end else begin
      wr_real_q <= wr_real_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  assign rd_sel_o = rd_sel_q;
`else
  assign rd_sel_o = '0;
`endif

  assign req_ready = ready_q;
  assign load_o    = load_q;
  assign din_o     = din_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;

endmodule
